// File: rtl/sccb_responder.sv
// SCCB/I2C target for the OV7670 configuration bus: filtered bus sampling, address match,
// register write strobes and register reads served from a persistent sub-address pointer.
module sccb_responder #(
    parameter logic [6:0] DEV_ADDR   = 7'h21,
    parameter int         FILTER_LEN = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sioc,
    input  logic       siod_in,
    output logic       siod_oe,
    output logic       busy,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_DEV, ST_DEV_ACK, ST_SUB, ST_SUB_ACK, ST_WR,
        ST_DATA_ACK, ST_RD, ST_RD_ACK, ST_RD_NEXT, ST_IGNORE
    } state_t;

    logic                  sioc_meta_r, siod_meta_r;
    logic [FILTER_LEN-1:0] sioc_hist_r, siod_hist_r;
    logic                  sioc_f_r, sioc_fd_r, siod_f_r, siod_fd_r;
    logic                  rise_s, fall_s, start_s, stop_s;

    state_t      state_r, state_n;
    logic [3:0]  cnt_r, cnt_n;
    logic [7:0]  shift_r, shift_n;
    logic [7:0]  ptr_r, ptr_n;
    logic        rw_r, rw_n;
    logic        oe_r, oe_n;
    logic        busy_r, busy_n;
    logic        wr_en_r, wr_en_n;
    logic [7:0]  wr_addr_r, wr_addr_n;
    logic [7:0]  wr_data_r, wr_data_n;
    logic [7:0]  byte_s;

    // Synchronizer (meta + hist[0]) followed by the equal-sample filter; idle bus level is high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sioc_meta_r <= 1'b1;
            siod_meta_r <= 1'b1;
            sioc_hist_r <= {FILTER_LEN{1'b1}};
            siod_hist_r <= {FILTER_LEN{1'b1}};
            sioc_f_r    <= 1'b1;
            siod_f_r    <= 1'b1;
            sioc_fd_r   <= 1'b1;
            siod_fd_r   <= 1'b1;
        end else begin
            sioc_meta_r    <= sioc;
            siod_meta_r    <= siod_in;
            sioc_hist_r[0] <= sioc_meta_r;
            siod_hist_r[0] <= siod_meta_r;
            for (int i = 1; i < FILTER_LEN; i++) begin
                sioc_hist_r[i] <= sioc_hist_r[i-1];
                siod_hist_r[i] <= siod_hist_r[i-1];
            end
            if (&sioc_hist_r)       sioc_f_r <= 1'b1;
            else if (~|sioc_hist_r) sioc_f_r <= 1'b0;
            else                    sioc_f_r <= sioc_f_r;
            if (&siod_hist_r)       siod_f_r <= 1'b1;
            else if (~|siod_hist_r) siod_f_r <= 1'b0;
            else                    siod_f_r <= siod_f_r;
            sioc_fd_r <= sioc_f_r;
            siod_fd_r <= siod_f_r;
        end
    end

    // START/STOP require SIOC high in both the current and previous filtered sample
    assign rise_s  = sioc_f_r & ~sioc_fd_r;
    assign fall_s  = ~sioc_f_r & sioc_fd_r;
    assign start_s = sioc_f_r & sioc_fd_r & ~siod_f_r & siod_fd_r;
    assign stop_s  = sioc_f_r & sioc_fd_r & siod_f_r & ~siod_fd_r;
    assign byte_s  = {shift_r[6:0], siod_f_r};

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 4'd0;
            shift_r   <= 8'h00;
            ptr_r     <= 8'h00;
            rw_r      <= 1'b0;
            oe_r      <= 1'b0;
            busy_r    <= 1'b0;
            wr_en_r   <= 1'b0;
            wr_addr_r <= 8'h00;
            wr_data_r <= 8'h00;
        end else begin
            state_r   <= state_n;
            cnt_r     <= cnt_n;
            shift_r   <= shift_n;
            ptr_r     <= ptr_n;
            rw_r      <= rw_n;
            oe_r      <= oe_n;
            busy_r    <= busy_n;
            wr_en_r   <= wr_en_n;
            wr_addr_r <= wr_addr_n;
            wr_data_r <= wr_data_n;
        end
    end

    // Next-state logic; STOP beats START beats ordinary bit handling
    always_comb begin
        state_n   = state_r;
        cnt_n     = cnt_r;
        shift_n   = shift_r;
        ptr_n     = ptr_r;
        rw_n      = rw_r;
        oe_n      = oe_r;
        busy_n    = busy_r;
        wr_en_n   = 1'b0;
        wr_addr_n = wr_addr_r;
        wr_data_n = wr_data_r;
        if (stop_s) begin
            state_n = ST_IDLE;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
        end else if (start_s) begin
            state_n = ST_DEV;
            cnt_n   = 4'd0;
            oe_n    = 1'b0;
            busy_n  = 1'b1;
        end else begin
            case (state_r)
                ST_DEV, ST_SUB, ST_WR: begin
                    if (rise_s) begin
                        shift_n = byte_s;
                        if (cnt_r == 4'd7) begin
                            cnt_n = 4'd0;
                            case (state_r)
                                ST_DEV: begin
                                    rw_n    = byte_s[0];
                                    state_n = (byte_s[7:1] == DEV_ADDR) ? ST_DEV_ACK : ST_IGNORE;
                                end
                                ST_SUB: begin
                                    ptr_n   = byte_s;
                                    state_n = ST_SUB_ACK;
                                end
                                default: begin
                                    wr_en_n   = 1'b1;
                                    wr_addr_n = ptr_r;
                                    wr_data_n = byte_s;
                                    ptr_n     = ptr_r + 8'd1;
                                    state_n   = ST_DATA_ACK;
                                end
                            endcase
                        end else begin
                            cnt_n = cnt_r + 4'd1;
                        end
                    end else begin
                        cnt_n = cnt_r;
                    end
                end
                // First fall pulls SIOD low, second fall ends the ACK slot
                ST_DEV_ACK, ST_SUB_ACK, ST_DATA_ACK: begin
                    if (fall_s && !oe_r) begin
                        oe_n = 1'b1;
                    end else if (fall_s) begin
                        oe_n = 1'b0;
                        if (state_r == ST_DEV_ACK && rw_r) begin
                            oe_n    = ~rd_data[7];
                            shift_n = {rd_data[6:0], 1'b0};
                            cnt_n   = 4'd1;
                            state_n = ST_RD;
                        end else if (state_r == ST_DEV_ACK) begin
                            state_n = ST_SUB;
                        end else begin
                            state_n = ST_WR;
                        end
                    end else begin
                        oe_n = oe_r;
                    end
                end
                ST_RD: begin
                    if (fall_s && cnt_r == 4'd8) begin
                        oe_n    = 1'b0;
                        cnt_n   = 4'd0;
                        state_n = ST_RD_ACK;
                    end else if (fall_s) begin
                        oe_n    = ~shift_r[7];
                        shift_n = {shift_r[6:0], 1'b0};
                        cnt_n   = cnt_r + 4'd1;
                    end else begin
                        oe_n = oe_r;
                    end
                end
                ST_RD_ACK: begin
                    if (rise_s && !siod_f_r) begin
                        ptr_n   = ptr_r + 8'd1;
                        state_n = ST_RD_NEXT;
                    end else if (rise_s) begin
                        state_n = ST_IGNORE;
                    end else begin
                        state_n = ST_RD_ACK;
                    end
                end
                ST_RD_NEXT: begin
                    if (fall_s) begin
                        oe_n    = ~rd_data[7];
                        shift_n = {rd_data[6:0], 1'b0};
                        cnt_n   = 4'd1;
                        state_n = ST_RD;
                    end else begin
                        state_n = ST_RD_NEXT;
                    end
                end
                ST_IGNORE: begin
                    oe_n = 1'b0;
                end
                ST_IDLE: begin
                    oe_n = 1'b0;
                end
                default: begin
                    state_n = ST_IDLE;
                    oe_n    = 1'b0;
                end
            endcase
        end
    end

    assign siod_oe = oe_r;
    assign busy    = busy_r;
    assign wr_en   = wr_en_r;
    assign wr_addr = wr_addr_r;
    assign wr_data = wr_data_r;
    assign rd_addr = ptr_r;

endmodule
